pipelined_shifter: RTL and testbench

- Registered, multi-mode barrel shifter with a valid/ready handshake on both sides and full backpressure.
- The log2(n) shift levels are split across STAGES pipeline register stages, so it sustains one operation per cycle at higher clock rates.
- Adds an arithmetic right shift and a carry-out (last bit shifted out) flag.
- Sits between operand issue and writeback in the ALU datapath.

---
 rtl/pipelined_shifter.sv | 101 ++++++++++
 tb/tb_pipelined_shifter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: multi-mode barrel shifter (LSL/LSR/ASR/ROL/ROR/pass) whose
// shift levels are spread over STAGES registered stages with valid/ready flow control.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 32
`endif

module pipelined_shifter #(
    parameter int n      = `DEFAULT_WIDTH,
    parameter int STAGES = $clog2(n)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [n-1:0]         a,
    input  logic [$clog2(n)-1:0] b,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [n-1:0]         out,
    output logic                 carry
);
    localparam int L = $clog2(n);
    localparam int P = (L + STAGES - 1) / STAGES;

    logic [n-1:0]        d_q [STAGES];
    logic [L-1:0]        b_q [STAGES];
    logic [2:0]          op_q[STAGES];
    logic [STAGES-1:0]   c_q, v_q, ld, vin, sc;
    logic [n-1:0]        sd  [STAGES];
    logic [n-1:0]        nd  [STAGES];
    logic [L-1:0]        sb  [STAGES];
    logic [2:0]          so  [STAGES];
    logic [L-1:0]        bm;
    logic                c_in;

    // ASR keeps the sign in the msb at every level, so the current msb is the fill bit
    function automatic logic [n-1:0] level(input logic [n-1:0] d, input logic [2:0] o, input int s);
        logic [n-1:0] asr;
        asr = (d >> s) | ({n{d[n-1]}} & ~({n{1'b1}} >> s));
        return o == 3'd0 ? d << s :
               o == 3'd1 ? d >> s :
               o == 3'd2 ? asr :
               o == 3'd3 ? (d << s) | (d >> (n - s)) :
               o == 3'd4 ? (d >> s) | (d << (n - s)) : d;
    endfunction

    always_comb begin
        bm = b - 1'b1;
        c_in = (b == '0 || op > 3'd4) ? 1'b0 : (op == 3'd0 || op == 3'd3) ? a[~bm] : a[bm];
        vin[0] = in_valid;
        sd[0] = a;
        sb[0] = b;
        so[0] = op;
        sc[0] = c_in;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = v_q[k-1];
            sd[k] = d_q[k-1];
            sb[k] = b_q[k-1];
            so[k] = op_q[k-1];
            sc[k] = c_q[k-1];
        end
        // a stage stalls only when it and every stage after it is full and the output is blocked
        for (int k = 0; k < STAGES; k++)
            ld[k] = out_ready || ((v_q >> k) != ({STAGES{1'b1}} >> k));
        for (int k = 0; k < STAGES; k++) begin
            nd[k] = sd[k];
            for (int i = 0; i < L; i++)
                if (i / P == k && sb[k][i]) nd[k] = level(nd[k], so[k], 1 << i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
                b_q[k] <= '0;
                op_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= vin[k];
                    if (vin[k]) begin
                        d_q[k] <= nd[k];
                        b_q[k] <= sb[k];
                        op_q[k] <= so[k];
                        c_q[k] <= sc[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];
    assign out       = d_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed-vector bench for pipelined_shifter (n=8/STAGES=3 plus n=32
// latency variants), with an in-order scoreboard checking every output transfer.
module tb_pipelined_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [2:0] b = '0;
    logic [2:0] op = '0;
    logic       in_ready, out_valid, carry;
    logic [7:0] out;

    pipelined_shifter #(.n(8), .STAGES(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .carry(carry)
    );

    logic        v32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [4:0]  b32 = '0;
    logic [2:0]  op32 = '0;
    logic [2:0]  rdy32, ov32, c32;
    logic [31:0] o32 [3];

    pipelined_shifter #(.n(32), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32[0]), .a(a32), .b(b32), .op(op32),
        .out_valid(ov32[0]), .out_ready(1'b1), .out(o32[0]), .carry(c32[0])
    );
    pipelined_shifter #(.n(32), .STAGES(2)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32[1]), .a(a32), .b(b32), .op(op32),
        .out_valid(ov32[1]), .out_ready(1'b1), .out(o32[1]), .carry(c32[1])
    );
    pipelined_shifter #(.n(32), .STAGES(5)) dut_s5 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32[2]), .a(a32), .b(b32), .op(op32),
        .out_valid(ov32[2]), .out_ready(1'b1), .out(o32[2]), .carry(c32[2])
    );

    int nvec = 0;
    int errs = 0;
    int cyc = 0;
    bit chk_lat = 1'b1;
    logic [7:0] exp_out = '0;
    logic       exp_c = 1'b0;

    typedef struct {
        logic [7:0] r;
        logic       c;
        int         cy;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic [7:0] a;
        logic [2:0] b;
        logic [2:0] op;
        logic [7:0] r;
        logic       c;
    } vec_t;
    vec_t tbl[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input int k, input int o);
        logic [7:0] r;
        logic c;
        for (int j = 0; j < 8; j++)
            r[j] = o == 0 ? (j >= k ? x[(j - k + 8) % 8] : 1'b0) :
                   o == 1 ? (j + k < 8 ? x[(j + k) % 8] : 1'b0) :
                   o == 2 ? (j + k < 8 ? x[(j + k) % 8] : x[7]) :
                   o == 3 ? x[(j - k + 8) % 8] :
                   o == 4 ? x[(j + k) % 8] : x[j];
        c = (k == 0 || o > 4) ? 1'b0 : (o == 0 || o == 3) ? x[(8 - k) % 8] : x[k - 1];
        return {c, r};
    endfunction

    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out_valid", 1, 0);
                else begin
                    ent_t e;
                    e = q.pop_front();
                    chk("out", out, e.r);
                    chk("carry", carry, e.c);
                    if (chk_lat) chk("latency", cyc - e.cy, 3);
                end
            end
            if (in_valid && in_ready) q.push_back('{exp_out, exp_c, cyc});
        end
    end

    task automatic send(input logic [7:0] ia, input logic [2:0] ib, input logic [2:0] io,
                        input logic [7:0] er, input logic ec);
        a = ia;
        b = ib;
        op = io;
        exp_out = er;
        exp_c = ec;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !in_ready; t++) tick();
        if (!in_ready) chk("send_in_ready", in_ready, 1);
        tick();
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && q.size() > 0; t++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic [8:0] m;
        logic [7:0] hold;
        logic       hc, r;
        int         acc;
        bit         pv[5];
        bit [2:0]   seen;
        int         st[3];
        logic [7:0] bp_a[5];

        tbl[0] = '{8'h87, 3'd3, 3'd0, 8'h38, 1'b0};
        tbl[1] = '{8'h87, 3'd1, 3'd1, 8'h43, 1'b1};
        tbl[2] = '{8'h87, 3'd2, 3'd2, 8'hE1, 1'b1};
        tbl[3] = '{8'h87, 3'd3, 3'd3, 8'h3C, 1'b0};
        tbl[4] = '{8'h87, 3'd4, 3'd4, 8'h78, 1'b0};
        pv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        st = '{1, 2, 5};
        bp_a = '{8'h90, 8'hA1, 8'h3C, 8'hF5, 8'h0E};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_carry", carry, 0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);

        foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r, tbl[i].c);
        in_valid = 1'b0;
        drain();

        for (int v = 0; v < 2; v++)
            for (int o = 0; o < 8; o++)
                for (int k = 0; k < 8; k++) begin
                    logic [7:0] x;
                    x = v == 0 ? 8'h87 : 8'h69;
                    m = model(x, k, o);
                    send(x, 3'(k), 3'(o), m[7:0], m[8]);
                end
        in_valid = 1'b0;
        drain();

        chk_lat = 1'b0;
        out_ready = 1'b0;
        acc = 0;
        for (int t = 0; t < 6; t++) begin
            m = model(bp_a[acc], acc + 1, acc);
            a = bp_a[acc];
            b = 3'(acc + 1);
            op = 3'(acc);
            exp_out = m[7:0];
            exp_c = m[8];
            in_valid = 1'b1;
            r = in_ready;
            tick();
            if (r) acc++;
        end
        chk("bp_accepted", acc, 3);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        hold = out;
        hc = carry;
        repeat (3) begin
            tick();
            chk("bp_hold_out", out, hold);
            chk("bp_hold_carry", carry, hc);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_full_in_ready", in_ready, 1);
        for (int i = acc; i < 5; i++) begin
            m = model(bp_a[i], i + 1, i);
            send(bp_a[i], 3'(i + 1), 3'(i), m[7:0], m[8]);
        end
        in_valid = 1'b0;
        drain();
        chk_lat = 1'b1;

        for (int t = 0; t < 10; t++) begin
            chk("bubble_out_valid", out_valid, (t >= 3 && t < 8) ? pv[t-3] : 1'b0);
            in_valid = t < 5 ? pv[t] : 1'b0;
            a = 8'(t + 1);
            b = 3'd2;
            op = 3'd5;
            exp_out = 8'(t + 1);
            exp_c = 1'b0;
            tick();
        end
        drain();

        send(8'h11, 3'd0, 3'd5, 8'h11, 1'b0);
        send(8'h22, 3'd0, 3'd5, 8'h22, 1'b0);
        send(8'h33, 3'd0, 3'd5, 8'h33, 1'b0);
        in_valid = 1'b0;
        chk("inflight_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", out, 0);
        chk("midrst_carry", carry, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("postrst_in_ready", in_ready, 1);
        send(8'h5A, 3'd1, 3'd0, 8'hB4, 1'b0);
        in_valid = 1'b0;
        for (int t = 0; t < 10 && !out_valid; t++) begin
            chk("postrst_out_zero", out, 0);
            tick();
        end
        chk("postrst_first_valid", out_valid, 1);
        chk("postrst_first_out", out, 8'hB4);
        drain();

        a32 = 32'h8000_0000;
        b32 = 5'd31;
        op32 = 3'd2;
        v32 = 1'b1;
        chk("w32_in_ready", rdy32, 3'b111);
        tick();
        v32 = 1'b0;
        seen = '0;
        for (int t = 1; t <= 8; t++) begin
            for (int j = 0; j < 3; j++)
                if (ov32[j] && !seen[j]) begin
                    seen[j] = 1'b1;
                    chk($sformatf("w32_latency_s%0d", st[j]), t, st[j]);
                    chk($sformatf("w32_out_s%0d", st[j]), o32[j], 32'hFFFF_FFFF);
                    chk($sformatf("w32_carry_s%0d", st[j]), c32[j], 0);
                end
            tick();
        end
        chk("w32_all_seen", seen, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
